// File: rtl/iis_defs.sv
// rtl/iis_defs.sv - shared IIS definitions for the ADC receiver and DAC transmit driver
package iis_defs;

  // Default bits per channel sample
  localparam int IIS_DATA_WIDTH = 16;

  // System clock must run at least this many times faster than BCLK
  localparam int IIS_MIN_OVERSAMPLE = 4;

  // Serial frame state machine encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } iis_state_t;

  // Number of serial bits in one {L,R} frame
  function automatic int frame_bits(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/iis_rx_fifo.sv
// rtl/iis_rx_fifo.sv - single-clock show-ahead FIFO for captured frames
module iis_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     Read_Clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign usedw = count;
  // A pop frees a slot in the same cycle, so a write into a full FIFO is accepted alongside it
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  // Head is presented combinationally; an empty FIFO shows zero
  assign dout  = empty ? '0 : mem[rptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge Read_Clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge Read_Clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iis_adc_receiver.sv
// rtl/iis_adc_receiver.sv - DSP-mode IIS ADC capture; IIS_RX_FRAME_CHECK_EN enables Frame_Err
module iis_adc_receiver
  import iis_defs::*;
#(
  parameter int DATA_WIDTH = IIS_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Read_Clk,
  input  logic                          rst_n,
  input  logic                          IIS_BCLK,
  input  logic                          IIS_ADCLRC,
  input  logic                          IIS_ADCDAT,
  output logic [2*DATA_WIDTH-1:0]       Data_Out,
  output logic                          Data_Valid,
  input  logic                          Read_Enable,
  output logic [$clog2(FIFO_DEPTH):0]   rdusedw,
  output logic                          Overflow,
  output logic                          Frame_Err
);

  localparam int FRAME_BITS = frame_bits(DATA_WIDTH);
  localparam int CNT_W      = $clog2(FRAME_BITS) + 1;

  logic bclk_meta, bclk_sync, bclk_prev;
  logic lrc_meta, lrc_sync;
  logic dat_meta, dat_sync;
  logic bclk_rise;
  logic lrc_q;

  iis_state_t              state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shift_reg;

  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  // Two-flop synchronizers for the codec pins plus a BCLK history bit for edge detect
  always_ff @(posedge Read_Clk) begin
    if (!rst_n) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_prev <= 1'b0;
      lrc_meta  <= 1'b0;
      lrc_sync  <= 1'b0;
      dat_meta  <= 1'b0;
      dat_sync  <= 1'b0;
    end else begin
      bclk_meta <= IIS_BCLK;
      bclk_sync <= bclk_meta;
      bclk_prev <= bclk_sync;
      lrc_meta  <= IIS_ADCLRC;
      lrc_sync  <= lrc_meta;
      dat_meta  <= IIS_ADCDAT;
      dat_sync  <= dat_meta;
    end
  end

  assign bclk_rise = bclk_sync & ~bclk_prev;

`ifdef IIS_RX_FRAME_CHECK_EN
  logic frame_err_q;
`endif

  // Frame FSM: a sync pulse followed by a low sample starts L MSB; an early sync aborts the frame
  always_ff @(posedge Read_Clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      lrc_q     <= 1'b0;
`ifdef IIS_RX_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
`ifdef IIS_RX_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
      if (bclk_rise) lrc_q <= lrc_sync;
      case (state)
        ST_IDLE: begin
          if (bclk_rise && lrc_q && !lrc_sync) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], dat_sync};
            bit_cnt   <= CNT_W'(1);
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bclk_rise) begin
            if (lrc_sync) begin
              // Sync arrived before the frame filled: drop the partial frame
              state <= ST_IDLE;
`ifdef IIS_RX_FRAME_CHECK_EN
              frame_err_q <= 1'b1;
`endif
            end else begin
              shift_reg <= {shift_reg[FRAME_BITS-2:0], dat_sync};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(FRAME_BITS - 1)) state <= ST_PUSH;
            end
          end
        end
        ST_PUSH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IIS_RX_FRAME_CHECK_EN
  assign Frame_Err = frame_err_q;
`else
  assign Frame_Err = 1'b0;
`endif

  assign push       = (state == ST_PUSH);
  assign Data_Valid = ~fifo_empty;
  assign pop        = Read_Enable & Data_Valid;

  // Sticky overflow: a completed frame found the FIFO full with no pop to make room
  always_ff @(posedge Read_Clk) begin
    if (!rst_n) begin
      Overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      Overflow <= 1'b1;
    end
  end

  iis_rx_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Read_Clk (Read_Clk),
    .rst_n    (rst_n),
    .wr       (push),
    .din      (shift_reg),
    .rd       (Read_Enable),
    .dout     (Data_Out),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .usedw    (rdusedw)
  );

endmodule

// File: tb/tb_iis_adc_receiver.sv
// tb/tb_iis_adc_receiver.sv - directed self-checking bench for iis_adc_receiver
module tb_iis_adc_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b0;
  logic        lrc = 1'b0;
  logic        dat = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        read_enable = 1'b0;
  logic [3:0]  rdusedw;
  logic        overflow;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;

  always #5 clk = ~clk;

  iis_adc_receiver dut (
    .Read_Clk    (clk),
    .rst_n       (rst_n),
    .IIS_BCLK    (bclk),
    .IIS_ADCLRC  (lrc),
    .IIS_ADCDAT  (dat),
    .Data_Out    (data_out),
    .Data_Valid  (data_valid),
    .Read_Enable (read_enable),
    .rdusedw     (rdusedw),
    .Overflow    (overflow),
    .Frame_Err   (frame_err)
  );

  // Count Frame_Err cycles
  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic do_reset;
    read_enable = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One BCLK period = 8 Read_Clk; codec changes pins while BCLK is low
  task automatic send_bit(input logic l, input logic d);
    bclk = 1'b0; lrc = l; dat = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] data, input int width);
    for (int i = 0; i < width; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 32; i++) send_bit(1'b0, data[31-i]);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'h0); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (rdusedw !== 4'd0) begin bad++; $display("FAIL reset_usedw got=%0d exp=0", rdusedw); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [31:0] d;
    int lat;
    d = 32'hA55A1234;
    lat = 0;
    do_reset();
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) send_bit(1'b0, d[31-i]);
    bclk = 1'b0; dat = d[0];
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (lat == 0 && data_valid === 1'b1) lat = k;
    end
    total++; if (lat == 0) begin bad++; $display("FAIL single_latency valid not seen within 5 clk"); end
    total++; if (data_out !== 32'hA55A1234) begin bad++; $display("FAIL single_data got=%h exp=%h", data_out, 32'hA55A1234); end
    total++; if (rdusedw !== 4'd1) begin bad++; $display("FAIL single_usedw got=%0d exp=1", rdusedw); end
    send_bit(1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(32'(i), 1);
    total++; if (rdusedw !== 4'd8) begin bad++; $display("FAIL ovf_usedw got=%0d exp=8", rdusedw); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (data_out !== 32'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, data_out, 32'(i)); end
      read_enable = 1'b1;
      @(negedge clk);
      read_enable = 1'b0;
    end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ovf_frame9_absent valid=%b exp=0", data_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] d;
    d = 32'h00000109;
    do_reset();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow_cleared got=%b exp=0", overflow); end
    for (int i = 1; i <= 8; i++) send_frame(32'h100 + 32'(i), 1);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) send_bit(1'b0, d[31-i]);
    bclk = 1'b0; dat = d[0];
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    // The frame is written on the 4th clock after the BCLK rise; pop on that same clock
    repeat (3) @(negedge clk);
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    send_bit(1'b0, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    total++; if (rdusedw !== 4'd8) begin bad++; $display("FAIL fpp_usedw got=%0d exp=8", rdusedw); end
    for (int i = 2; i <= 9; i++) begin
      total++; if (data_out !== 32'h100 + 32'(i)) begin bad++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, data_out, 32'h100 + 32'(i)); end
      read_enable = 1'b1;
      @(negedge clk);
      read_enable = 1'b0;
    end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty valid=%b exp=0", data_valid); end
  endtask

  task automatic test_short_frame;
    logic [31:0] junk;
    int fe_start;
    int fe_exp;
`ifdef IIS_RX_FRAME_CHECK_EN
    fe_exp = 1;
`else
    fe_exp = 0;
`endif
    junk = 32'h5A5A5A5A;
    do_reset();
    fe_start = fe_cnt;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'b0, junk[31-i]);
    send_frame(32'hDEADBEEF, 1);
    total++; if (rdusedw !== 4'd1) begin bad++; $display("FAIL short_usedw got=%0d exp=1", rdusedw); end
    total++; if (data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL short_data got=%h exp=%h", data_out, 32'hDEADBEEF); end
    total++; if (fe_cnt - fe_start != fe_exp) begin bad++; $display("FAIL short_frame_err pulses=%0d exp=%0d", fe_cnt - fe_start, fe_exp); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] junk;
    junk = 32'hFFFF00FF;
    do_reset();
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0, junk[31-i]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 10; i < 32; i++) send_bit(1'b0, junk[31-i]);
    send_bit(1'b0, 1'b0);
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_partial valid=%b exp=0", data_valid); end
    send_frame(32'h0F0FF0F0, 1);
    total++; if (rdusedw !== 4'd1) begin bad++; $display("FAIL rstmid_usedw got=%0d exp=1", rdusedw); end
    total++; if (data_out !== 32'h0F0FF0F0) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", data_out, 32'h0F0FF0F0); end
  endtask

  task automatic test_wide_lrc;
    do_reset();
    send_frame(32'h80000001, 3);
    total++; if (rdusedw !== 4'd1) begin bad++; $display("FAIL wide_usedw got=%0d exp=1", rdusedw); end
    total++; if (data_out !== 32'h80000001) begin bad++; $display("FAIL wide_data got=%h exp=%h", data_out, 32'h80000001); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_short_frame();
    test_reset_mid_frame();
    test_wide_lrc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
